// File: rtl/sequenciador_ula_pkg.sv
// -----------------------------------------------------------------------------
// sequenciador_ula_pkg
// Shared definitions for the ALU sequencer: default datapath sizes, ALU
// opcode constants and the sequencer FSM state type.
// -----------------------------------------------------------------------------
package sequenciador_ula_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int NREGS_DEF = 8;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_NAND = 3'b100;
  localparam logic [2:0] OP_XNOR = 3'b101;
  localparam logic [2:0] OP_NOTA = 3'b110;
  localparam logic [2:0] OP_PASS = 3'b111;

  typedef enum logic [1:0] {
    OCIOSO = 2'b00,
    OPER   = 2'b01,
    ESCR   = 2'b10
  } estado_t;

endpackage

// File: rtl/banco_registradores_8x32.sv
// -----------------------------------------------------------------------------
// banco_registradores_8x32
// Register file with two asynchronous read ports and one synchronous write
// port. All entries clear asynchronously on reset.
//   clk, rst_n        : clock, asynchronous active-low reset
//   i_we/i_waddr/i_wdata : write port
//   i_raddr_a/b       : read addresses
//   o_rdata_a/b       : combinational read data
// -----------------------------------------------------------------------------
module banco_registradores_8x32
  import sequenciador_ula_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr_a,
  input  logic [AW-1:0]    i_raddr_b,
  output logic [WIDTH-1:0] o_rdata_a,
  output logic [WIDTH-1:0] o_rdata_b
);

  logic [WIDTH-1:0] r_mem [NREGS];

  // Storage array: asynchronous clear, single write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        r_mem[i] <= {WIDTH{1'b0}};
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = r_mem[i_raddr_a];
  assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/sequenciador_ula.sv
// -----------------------------------------------------------------------------
// sequenciador_ula
// Three-cycle execute unit wrapped around an external combinational ALU.
// An instruction accepted in OCIOSO drives registered operands/op/carry-ins
// to the ALU during OPER; the ALU result and flags are captured at the end of
// OPER and written back; ESCR signals completion with res_valid.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   instr_valid/instr_ready    : instruction handshake
//   instr_op/rd/ra/rb/usa_flag : instruction fields
//   wr_en/wr_addr/wr_data      : external register write (idle only)
//   ula_a/b/op/cin/bin         : registered ALU inputs
//   ula_resultado/cout/bout    : ALU outputs
//   res_valid/res_data         : writeback pulse and last result
//   flag_c/flag_b/flag_z       : carry, borrow and zero flags
//   busy                       : inverse of instr_ready
// -----------------------------------------------------------------------------
module sequenciador_ula
  import sequenciador_ula_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [2:0]       instr_op,
  input  logic [AW-1:0]    instr_rd,
  input  logic [AW-1:0]    instr_ra,
  input  logic [AW-1:0]    instr_rb,
  input  logic             instr_usa_flag,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] ula_a,
  output logic [WIDTH-1:0] ula_b,
  output logic [2:0]       ula_op,
  output logic             ula_cin,
  output logic             ula_bin,
  input  logic [WIDTH-1:0] ula_resultado,
  input  logic             ula_cout,
  input  logic             ula_bout,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_data,
  output logic             flag_c,
  output logic             flag_b,
  output logic             flag_z,
  output logic             busy
);

  estado_t          r_estado;
  estado_t          w_prox_estado;
  logic             w_aceita;
  logic [AW-1:0]    r_rd;

  logic             w_rf_we;
  logic [AW-1:0]    w_rf_waddr;
  logic [WIDTH-1:0] w_rf_wdata;
  logic [WIDTH-1:0] w_rd_a;
  logic [WIDTH-1:0] w_rd_b;

  logic [WIDTH-1:0] r_ula_a;
  logic [WIDTH-1:0] r_ula_b;
  logic [2:0]       r_ula_op;
  logic             r_ula_cin;
  logic             r_ula_bin;
  logic             r_res_valid;
  logic [WIDTH-1:0] r_res_data;
  logic             r_flag_c;
  logic             r_flag_b;
  logic             r_flag_z;

  banco_registradores_8x32 #(
    .WIDTH (WIDTH),
    .NREGS (NREGS),
    .AW    (AW)
  ) u_banco (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_we      (w_rf_we),
    .i_waddr   (w_rf_waddr),
    .i_wdata   (w_rf_wdata),
    .i_raddr_a (instr_ra),
    .i_raddr_b (instr_rb),
    .o_rdata_a (w_rd_a),
    .o_rdata_b (w_rd_b)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_estado <= OCIOSO;
    end else begin
      r_estado <= w_prox_estado;
    end
  end

  // Next-state logic and register-file write-port mux. In OPER the writeback
  // owns the port, so an external write arriving then is simply dropped.
  always_comb begin
    w_prox_estado = r_estado;
    w_aceita      = 1'b0;
    w_rf_we       = 1'b0;
    w_rf_waddr    = wr_addr;
    w_rf_wdata    = wr_data;
    case (r_estado)
      OCIOSO: begin
        if (instr_valid) begin
          w_aceita      = 1'b1;
          w_prox_estado = OPER;
        end else begin
          w_prox_estado = OCIOSO;
        end
        if (wr_en) begin
          w_rf_we = 1'b1;
        end else begin
          w_rf_we = 1'b0;
        end
      end
      OPER: begin
        w_rf_we       = 1'b1;
        w_rf_waddr    = r_rd;
        w_rf_wdata    = ula_resultado;
        w_prox_estado = ESCR;
      end
      ESCR: begin
        w_prox_estado = OCIOSO;
      end
      default: begin
        w_prox_estado = OCIOSO;
      end
    endcase
  end

  // Operand latch at accept. Reads are combinational from the register file
  // before the edge, so a simultaneous external write is not yet visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ula_a   <= {WIDTH{1'b0}};
      r_ula_b   <= {WIDTH{1'b0}};
      r_ula_op  <= 3'b000;
      r_ula_cin <= 1'b0;
      r_ula_bin <= 1'b0;
      r_rd      <= {AW{1'b0}};
    end else if (w_aceita) begin
      r_ula_a   <= w_rd_a;
      r_ula_b   <= w_rd_b;
      r_ula_op  <= instr_op;
      r_ula_cin <= instr_usa_flag & r_flag_c & (instr_op == OP_ADD);
      r_ula_bin <= instr_usa_flag & r_flag_b & (instr_op == OP_SUB);
      r_rd      <= instr_rd;
    end
  end

  // Result capture and flag update at the end of OPER; res_valid is high
  // exactly for the ESCR cycle that follows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res_valid <= 1'b0;
      r_res_data  <= {WIDTH{1'b0}};
      r_flag_c    <= 1'b0;
      r_flag_b    <= 1'b0;
      r_flag_z    <= 1'b0;
    end else begin
      r_res_valid <= (r_estado == OPER);
      if (r_estado == OPER) begin
        r_res_data <= ula_resultado;
        r_flag_z   <= (ula_resultado == {WIDTH{1'b0}});
        if (r_ula_op == OP_ADD) begin
          r_flag_c <= ula_cout;
        end
        if (r_ula_op == OP_SUB) begin
          r_flag_b <= ula_bout;
        end
      end
    end
  end

  assign instr_ready = (r_estado == OCIOSO);
  assign busy        = ~instr_ready;
  assign ula_a       = r_ula_a;
  assign ula_b       = r_ula_b;
  assign ula_op      = r_ula_op;
  assign ula_cin     = r_ula_cin;
  assign ula_bin     = r_ula_bin;
  assign res_valid   = r_res_valid;
  assign res_data    = r_res_data;
  assign flag_c      = r_flag_c;
  assign flag_b      = r_flag_b;
  assign flag_z      = r_flag_z;

endmodule
